// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending (scoreboard) bits for the pipelined core.
// Optional macro REGFILE_SB_BYPASS_EN enables same-cycle writeback-to-read forwarding.
module regfile_scoreboard #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    output logic                   hazard,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic [AW:0]            pend_cnt
);

    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("regfile_scoreboard: NUM_RD must be in 1..4");
    end
    if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
        $error("regfile_scoreboard: NREGS must be a power of two and at least 2");
    end

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [XLEN-1:0]        r_regs [NREGS];
    logic [NREGS-1:0]       r_pend;
    logic [AW:0]            r_pend_cnt;

    logic                   w_wb_fire;
    logic                   w_iss_fire;
    logic [NREGS-1:0]       w_wb_mask;
    logic [NREGS-1:0]       w_iss_mask;
    logic [NREGS-1:0]       w_pend_nxt;
    logic [NUM_RD*XLEN-1:0] w_rd_data;
    logic [NUM_RD-1:0]      w_rd_busy;

    // Address 0 is never written or claimed, so it stays zero and never pending.
    assign w_wb_fire  = wb_en && (wb_addr != {AW{1'b0}});
    assign w_iss_fire = iss_valid && (iss_rd != {AW{1'b0}}) && !flush;

    // Next pending vector: writeback clears, a newer claim sets, flush wipes everything.
    always_comb begin
        w_wb_mask  = w_wb_fire  ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_addr) : {NREGS{1'b0}};
        w_iss_mask = w_iss_fire ? ({{(NREGS-1){1'b0}}, 1'b1} << iss_rd)  : {NREGS{1'b0}};
        w_pend_nxt = flush ? {NREGS{1'b0}} : ((r_pend & ~w_wb_mask) | w_iss_mask);
    end

    // Register array storage; flush never touches data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_wb_fire) begin
            r_regs[wb_addr] <= wb_data;
        end else begin
            r_regs[wb_addr] <= r_regs[wb_addr];
        end
    end

    // Pending bits and their registered population count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= {NREGS{1'b0}};
            r_pend_cnt <= {(AW+1){1'b0}};
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= popcount(w_pend_nxt);
        end
    end

    // Independent combinational read ports.
    always_comb begin
        w_rd_data = {(NUM_RD*XLEN){1'b0}};
        w_rd_busy = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wb_fire && (wb_addr == rd_addr[k*AW +: AW])) begin
                // Forwarded data is only still busy if a newer claim lands this cycle.
                w_rd_data[k*XLEN +: XLEN] = wb_data;
                w_rd_busy[k]              = w_iss_fire && (iss_rd == wb_addr);
            end else begin
                w_rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
                w_rd_busy[k]              = r_pend[rd_addr[k*AW +: AW]];
            end
`else
            w_rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
            w_rd_busy[k]              = r_pend[rd_addr[k*AW +: AW]];
`endif
        end
    end

    assign rd_data  = w_rd_data;
    assign rd_busy  = w_rd_busy;
    assign hazard   = |w_rd_busy;
    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard against an array-based reference model.
// Builds with or without REGFILE_SB_BYPASS_EN; expectations follow the macro.
module tb_regfile_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   hazard;
    logic                   iss_valid;
    logic [AW-1:0]          iss_rd;
    logic                   wb_en;
    logic [AW-1:0]          wb_addr;
    logic [XLEN-1:0]        wb_data;
    logic                   flush;
    logic [AW:0]            pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .hazard(hazard), .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .pend_cnt(pend_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (wb_en && wb_addr != 0) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end else if (iss_valid && iss_rd != 0) begin
            m_pend[iss_rd] = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        bit              eb;
        bit              any_busy;
        any_busy = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            a  = rd_addr[k*AW +: AW];
            ed = (a == 0) ? '0 : m_regs[a];
            eb = m_pend[a];
`ifdef REGFILE_SB_BYPASS_EN
            if (wb_en && wb_addr != 0 && wb_addr == a) begin
                ed = wb_data;
                eb = iss_valid && !flush && (iss_rd == wb_addr);
            end
`endif
            any_busy |= eb;
            check_eq($sformatf("rd_data%0d[a=%0d]", k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
            check_eq($sformatf("rd_busy%0d[a=%0d]", k, a), 64'(rd_busy[k]), 64'(eb));
        end
        check_eq("hazard", 64'(hazard), 64'(any_busy));
        check_eq("pend_cnt", 64'(pend_cnt), 64'(m_count()));
    endtask

    task automatic set_idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        iss_valid = 1'b0; iss_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
        rd_addr = {a1, a0};
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        set_idle(5'd0, 5'd0);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        settle(); tick();
    endtask

    task automatic do_claim(input logic [AW-1:0] a);
        set_idle(5'd0, 5'd0);
        iss_valid = 1'b1; iss_rd = a;
        settle(); tick();
    endtask

    task automatic do_flush();
        set_idle(5'd0, 5'd0);
        flush = 1'b1;
        settle(); tick();
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            iss_valid = 1'($urandom_range(1, 0));
            wb_en     = 1'($urandom_range(1, 0));
            wb_addr   = 5'($urandom_range(NREGS - 1, 0));
            wb_data   = $urandom;
            iss_rd    = ($urandom_range(3, 0) == 0) ? wb_addr : 5'($urandom_range(NREGS - 1, 0));
            flush     = ($urandom_range(15, 0) == 0);
            for (int k = 0; k < NUM_RD; k++) begin
                rd_addr[k*AW +: AW] = ($urandom_range(3, 0) == 0) ? wb_addr
                                                                  : 5'($urandom_range(NREGS - 1, 0));
            end
            settle(); tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        set_idle(5'd7, 5'd9);
        model_reset();
        #12;
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        check_eq("rst_rd_busy", 64'(rd_busy), 64'd0);
        check_eq("rst_hazard", 64'(hazard), 64'd0);
        check_eq("rst_pend_cnt", 64'(pend_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Sweep every address on both ports out of reset.
        for (int i = 0; i < NREGS / 2; i++) begin
            set_idle(5'(2 * i), 5'(2 * i + 1));
            settle(); tick();
        end

        do_wb(5'd5, 32'hDEADBEEF);
        set_idle(5'd5, 5'd0);
        settle();
        check_eq("wr5_port0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check_eq("wr5_port1", 64'(rd_data[63:32]), 64'd0);
        tick();

        do_wb(5'd0, 32'h00001234);
        set_idle(5'd0, 5'd5);
        settle();
        check_eq("wr0_reads_zero", 64'(rd_data[31:0]), 64'd0);
        check_eq("wr0_pend_cnt", 64'(pend_cnt), 64'd0);
        tick();

        do_claim(5'd7); do_claim(5'd9); do_claim(5'd7);
        set_idle(5'd7, 5'd0);
        settle();
        check_eq("claim_pend_cnt", 64'(pend_cnt), 64'd2);
        check_eq("claim_busy7", 64'(rd_busy[0]), 64'd1);
        check_eq("claim_hazard", 64'(hazard), 64'd1);
        tick();
        do_wb(5'd7, 32'h00000055);
        set_idle(5'd7, 5'd0);
        settle();
        check_eq("wb7_pend_cnt", 64'(pend_cnt), 64'd1);
        check_eq("wb7_busy", 64'(rd_busy[0]), 64'd0);
        check_eq("wb7_data", 64'(rd_data[31:0]), 64'h55);
        tick();

        do_flush();
        set_idle(5'd0, 5'd0);
        iss_valid = 1'b1; iss_rd = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
        settle(); tick();
        set_idle(5'd3, 5'd3);
        settle();
        check_eq("same_cyc_data", 64'(rd_data[31:0]), 64'hA5A5A5A5);
        check_eq("same_cyc_busy", 64'(rd_busy[1]), 64'd1);
        check_eq("same_cyc_pend_cnt", 64'(pend_cnt), 64'd1);
        tick();

        do_flush();
        do_claim(5'd2); do_claim(5'd4); do_claim(5'd6);
        set_idle(5'd2, 5'd6);
        settle();
        check_eq("pre_flush_cnt", 64'(pend_cnt), 64'd3);
        tick();
        set_idle(5'd0, 5'd0);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h00000077;
        settle(); tick();
        set_idle(5'd8, 5'd4);
        settle();
        check_eq("flush_pend_cnt", 64'(pend_cnt), 64'd0);
        check_eq("flush_busy8", 64'(rd_busy[0]), 64'd0);
        check_eq("flush_data4", 64'(rd_data[63:32]), 64'h77);
        tick();

        do_wb(5'd10, 32'h00000011);
        do_claim(5'd10);
        set_idle(5'd0, 5'd10);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hCAFEF00D;
        settle();
`ifdef REGFILE_SB_BYPASS_EN
        check_eq("byp_same_data", 64'(rd_data[63:32]), 64'hCAFEF00D);
        check_eq("byp_same_busy", 64'(rd_busy[1]), 64'd0);
`else
        check_eq("nobyp_same_data", 64'(rd_data[63:32]), 64'h11);
        check_eq("nobyp_same_busy", 64'(rd_busy[1]), 64'd1);
`endif
        tick();
        set_idle(5'd0, 5'd10);
        settle();
        check_eq("byp_next_data", 64'(rd_data[63:32]), 64'hCAFEF00D);
        check_eq("byp_next_busy", 64'(rd_busy[1]), 64'd0);
        tick();

        random_cycles(400);

        // Asynchronous reset in the middle of a cycle with a pending, written register.
        do_wb(5'd12, 32'h0000ABCD);
        do_claim(5'd12);
        set_idle(5'd12, 5'd12);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_rd_data", 64'(rd_data), 64'd0);
        check_eq("arst_rd_busy", 64'(rd_busy), 64'd0);
        check_eq("arst_hazard", 64'(hazard), 64'd0);
        check_eq("arst_pend_cnt", 64'(pend_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_idle(5'd12, 5'd5);
        settle(); tick();
        random_cycles(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle core's integer register file, built for the pipelined core.
- Adds a configurable number of read ports and a per-register pending (scoreboard) bit: set when an instruction claims a destination at issue, cleared at writeback.
- Also adds a registered pending-count counter and a flush path.
- Sits between decode/issue (reads, destination claim) and writeback; issue uses `rd_busy`/`hazard` to stall.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, at least 2). Register 0 is hardwired zero.
- NUM_RD, 2, number of independent read ports (1..4).
- AW, derived localparam = clog2(NREGS), address width. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
- rd_busy  out  NUM_RD  pending bit of the register addressed by each port.
- hazard  out  1  OR of all `rd_busy` bits.
- iss_valid  in  1  destination claim strobe.
- iss_rd  in  AW  destination register claimed.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register.
- wb_data  in  XLEN  writeback data.
- flush  in  1  clear all pending bits (pipeline flush).
- pend_cnt  out  AW+1  number of registers currently pending (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers cleared to 0 and all pending bits cleared;
  - pend_cnt=0; rd_data, rd_busy and hazard read 0.
  - Reset asserted mid-operation discards all in-flight claims immediately.
- Register 0:
  - always reads 0 and is never pending;
  - writes and claims to address 0 are ignored and do not change pend_cnt.
- Write: on posedge clk, if wb_en and wb_addr≠0, then reg[wb_addr] <= wb_data and pending[wb_addr] <= 0.
- Claim: on posedge clk, if iss_valid, iss_rd≠0 and flush=0, then pending[iss_rd] <= 1.
  - A claim to an already-pending register leaves it set (single bit, no nesting).
- Same-cycle claim and writeback to the same register:
  - data is written;
  - the pending bit ends at 1, because the newer claim wins.
- Flush: on posedge clk, all pending bits <= 0 and the same-cycle claim is dropped.
  - A same-cycle writeback still writes data.
  - Data is never cleared by flush.
- Read path: combinational from the array, all ports independent. Identical addresses on multiple ports are legal.
- pend_cnt:
  - registered; equals the population count of the pending bits after each clock edge;
  - range 0..NREGS-1, cannot overflow AW+1 bits;
  - goes to 0 on the edge where flush is sampled.
- `hazard` is combinational from `rd_busy`.
- Invalid parameters (NUM_RD outside 1..4, NREGS not a power of two) trigger an elaboration-time error.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined (write-through bypass):
  - if wb_en, wb_addr≠0 and wb_addr==rd_addr port k, then rd_data port k = wb_data in the same cycle;
  - rd_busy port k = 0 unless the same-cycle iss_rd equals wb_addr with iss_valid=1 and flush=0.
  - Zero-cycle writeback-to-read forwarding.
- Undefined: rd_data and rd_busy reflect array/pending state only; writeback is visible the cycle after the edge.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, hazard=0, pend_cnt=0. Assert rst mid-test after writes -> all outputs return to 0 asynchronously.
- Write reg5=0xDEADBEEF, then read ports (5,0) next cycle -> port0=0xDEADBEEF, port1=0. Write reg0=0x1234 -> reg0 still reads 0, pend_cnt unchanged.
- Claim reg7, reg9, then reg7 again -> pend_cnt=2; reading 7 gives rd_busy[0]=1, hazard=1. Writeback reg7=0x55 -> pend_cnt=1, rd_busy for 7 =0.
- Same cycle iss_rd=3 and wb_addr=3, wb_data=0xA5A5A5A5 -> next cycle reg3=0xA5A5A5A5, pending[3]=1, pend_cnt=1.
- Claim reg2, reg4, reg6 (pend_cnt=3), then flush with iss_rd=8 and wb reg4=0x77 -> pend_cnt=0, reg8 not pending, reg4=0x77.
- With bypass: wb reg10=0xCAFEF00D while port1 reads 10 and reg10 is pending -> same cycle rd_data1=0xCAFEF00D, rd_busy[1]=0. Without bypass -> old value and busy=1 that cycle, new value and busy=0 the next cycle.
